// File: rtl/alu_pkg.sv
// Shared ALU-side constants: flag bit positions, bus byte layout and the
// branch-condition encoding used by the flags register.
package alu_pkg;

    localparam int FLAG_W    = 5;
    localparam int FLAG_V    = 0;
    localparam int FLAG_S    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_CA   = 3;
    localparam int FLAG_CL   = 4;

    localparam int BUS_W     = 8;
    localparam int BUS_PAD_W = BUS_W - FLAG_W;

    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_V      = 4'd1;
    localparam logic [3:0] COND_NV     = 4'd2;
    localparam logic [3:0] COND_S      = 4'd3;
    localparam logic [3:0] COND_NS     = 4'd4;
    localparam logic [3:0] COND_Z      = 4'd5;
    localparam logic [3:0] COND_NZ     = 4'd6;
    localparam logic [3:0] COND_CA     = 4'd7;
    localparam logic [3:0] COND_NCA    = 4'd8;
    localparam logic [3:0] COND_CL     = 4'd9;
    localparam logic [3:0] COND_NCL    = 4'd10;
    localparam logic [3:0] COND_CA_Z   = 4'd11;
    localparam logic [3:0] COND_NCA_NZ = 4'd12;
    localparam logic [3:0] COND_LT     = 4'd13;
    localparam logic [3:0] COND_GE     = 4'd14;
    localparam logic [3:0] COND_NEVER  = 4'd15;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/flags_register_if.sv
// Link between the flags register and its shadow stack. push/pop are single-cycle
// strobes sampled on the rising edge; rd_data is always the current top of stack.
interface flags_register_if
    import alu_pkg::*;
#(
    parameter int PTR_W = 2
);
    logic           push;
    logic           pop;
    flags_t         wr_data;
    flags_t         rd_data;
    logic           pop_ok;
    logic [PTR_W:0] depth;
    logic           err;

    modport master (
        output push, pop, wr_data,
        input  rd_data, pop_ok, depth, err
    );

    modport slave (
        input  push, pop, wr_data,
        output rd_data, pop_ok, depth, err
    );
endinterface

// File: rtl/flags_stack.sv
// Shadow LIFO for interrupt entry/exit: depth counter plus a sticky error for
// pushing when full or popping when empty. Push and pop together cancel out.
module flags_stack
    import alu_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    flags_register_if.slave  s_if
);

    localparam logic [PTR_W:0] FULL_DEPTH = (PTR_W + 1)'(STACK_DEPTH);

    flags_t         r_mem [STACK_DEPTH];
    logic [PTR_W:0] r_depth;
    logic           r_err;

    logic             w_push_only;
    logic             w_pop_only;
    logic             w_full;
    logic             w_empty;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_top_idx;

    assign w_push_only = s_if.push & ~s_if.pop;
    assign w_pop_only  = s_if.pop & ~s_if.push;
    assign w_full      = (r_depth == FULL_DEPTH);
    assign w_empty     = (r_depth == '0);
    assign w_wr_idx    = r_depth[PTR_W-1:0];
    assign w_top_idx   = w_wr_idx - 1'b1;

    // Contents need no reset: depth alone decides which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push_only && !w_full) begin
            r_mem[w_wr_idx] <= s_if.wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push_only) begin
                if (w_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_depth <= r_depth + 1'b1;
                end
            end
            if (w_pop_only) begin
                if (w_empty) begin
                    r_err <= 1'b1;
                end else begin
                    r_depth <= r_depth - 1'b1;
                end
            end
        end
    end

    assign s_if.rd_data = r_mem[w_top_idx];
    assign s_if.pop_ok  = w_pop_only & ~w_empty;
    assign s_if.depth   = r_depth;
    assign s_if.err     = r_err;

endmodule

// File: rtl/flags_register.sv
// Architectural flags register behind the ALU: captures V/S/Z/CA/CL, shares the
// flags byte on MainBus, saves/restores via a shadow stack and evaluates branches.
module flags_register
    import alu_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Flags_0_Overflow,
    input  logic              Flags_1_Sign,
    input  logic              Flags_2_Zero,
    input  logic              Flags_3_CarryA,
    input  logic              Flags_4_CarryL,
    input  logic              FlagsLatch,
    inout  wire  [BUS_W-1:0]  MainBus,
    input  logic              Flags_Load_n,
    input  logic              Flags_Assert_n,
    input  logic              StackPush,
    input  logic              StackPop,
    input  logic [3:0]        Cond,
    output logic              CondTaken,
    output logic              LCarryIn,
    output logic [FLAG_W-1:0] FlagsOut,
    output logic [PTR_W:0]    StackDepth,
    output logic              StackErr
);

    flags_t r_flags;
    flags_t w_alu;
    flags_t w_bus_flags;
    flags_t w_eff;
    logic   w_load;
    logic   w_unused_bus_hi;

    flags_register_if #(.PTR_W(PTR_W)) w_stk_if ();

    flags_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .PTR_W       (PTR_W)
    ) u_stack (
        .i_clk (Clock),
        .i_rst (Reset),
        .s_if  (w_stk_if.slave)
    );

    assign w_alu = {Flags_4_CarryL, Flags_3_CarryA, Flags_2_Zero, Flags_1_Sign, Flags_0_Overflow};
    assign w_load          = ~Flags_Load_n;
    assign w_bus_flags     = MainBus[FLAG_W-1:0];
    assign w_unused_bus_hi = ^MainBus[BUS_W-1:FLAG_W];

    assign w_stk_if.push    = StackPush;
    assign w_stk_if.pop     = StackPop;
    assign w_stk_if.wr_data = r_flags;

    // Bus load beats a valid pop, which beats a fresh ALU result.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_flags <= '0;
        end else if (w_load) begin
            r_flags <= w_bus_flags;
        end else if (w_stk_if.pop_ok) begin
            r_flags <= w_stk_if.rd_data;
        end else if (FlagsLatch) begin
            r_flags <= w_alu;
        end
    end

    assign MainBus    = !Flags_Assert_n ? {{BUS_PAD_W{1'b0}}, r_flags} : {BUS_W{1'bz}};
    assign FlagsOut   = r_flags;
    assign LCarryIn   = r_flags[FLAG_CL];
    assign StackDepth = w_stk_if.depth;
    assign StackErr   = w_stk_if.err;

    // Branches see this cycle's ALU flags when they are about to be captured.
    assign w_eff = (FlagsLatch && !w_load && !w_stk_if.pop_ok) ? w_alu : r_flags;

    always_comb begin
        CondTaken = 1'b0;
        case (Cond)
            COND_ALWAYS: CondTaken = 1'b1;
            COND_V:      CondTaken = w_eff[FLAG_V];
            COND_NV:     CondTaken = ~w_eff[FLAG_V];
            COND_S:      CondTaken = w_eff[FLAG_S];
            COND_NS:     CondTaken = ~w_eff[FLAG_S];
            COND_Z:      CondTaken = w_eff[FLAG_Z];
            COND_NZ:     CondTaken = ~w_eff[FLAG_Z];
            COND_CA:     CondTaken = w_eff[FLAG_CA];
            COND_NCA:    CondTaken = ~w_eff[FLAG_CA];
            COND_CL:     CondTaken = w_eff[FLAG_CL];
            COND_NCL:    CondTaken = ~w_eff[FLAG_CL];
            COND_CA_Z:   CondTaken = w_eff[FLAG_CA] | w_eff[FLAG_Z];
            COND_NCA_NZ: CondTaken = ~w_eff[FLAG_CA] & ~w_eff[FLAG_Z];
            COND_LT:     CondTaken = w_eff[FLAG_S] ^ w_eff[FLAG_V];
            COND_GE:     CondTaken = ~(w_eff[FLAG_S] ^ w_eff[FLAG_V]);
            COND_NEVER:  CondTaken = 1'b0;
            default:     CondTaken = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_flags_register.sv
// Directed bench for flags_register: a reference model predicts each captured
// flags value into a queue that is drained and compared after every edge.
`timescale 1ns/1ps
module tb_flags_register;
    import alu_pkg::*;

    localparam int STACK_DEPTH = 4;
    localparam int PTR_W       = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [4:0]     alu;
    logic           latch, load_n, assert_n, push, pop;
    logic [3:0]     cond;
    logic           drv_en;
    logic [7:0]     drv;
    wire  [7:0]     main_bus;
    logic           cond_taken, lcarry, err;
    logic [4:0]     flags_out;
    logic [PTR_W:0] depth;

    logic [4:0] m_f;
    logic [4:0] m_stk[$];
    logic       m_err;
    logic [4:0] exp_q[$];
    int         n_chk = 0;
    int         n_pass = 0;

    always #50 clk = ~clk;

    assign main_bus = drv_en ? drv : 8'hzz;
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (main_bus[gi]);
    end

    flags_register #(.STACK_DEPTH(STACK_DEPTH), .PTR_W(PTR_W)) dut (
        .Clock(clk), .Reset(rst),
        .Flags_0_Overflow(alu[0]), .Flags_1_Sign(alu[1]), .Flags_2_Zero(alu[2]),
        .Flags_3_CarryA(alu[3]), .Flags_4_CarryL(alu[4]),
        .FlagsLatch(latch), .MainBus(main_bus),
        .Flags_Load_n(load_n), .Flags_Assert_n(assert_n),
        .StackPush(push), .StackPop(pop), .Cond(cond),
        .CondTaken(cond_taken), .LCarryIn(lcarry), .FlagsOut(flags_out),
        .StackDepth(depth), .StackErr(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic cond_model(input logic [3:0] c, input logic [4:0] e);
        logic v, s, z, ca, cl;
        {cl, ca, z, s, v} = e;
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return v;
            4'd2:  return !v;
            4'd3:  return s;
            4'd4:  return !s;
            4'd5:  return z;
            4'd6:  return !z;
            4'd7:  return ca;
            4'd8:  return !ca;
            4'd9:  return cl;
            4'd10: return !cl;
            4'd11: return ca || z;
            4'd12: return !ca && !z;
            4'd13: return s != v;
            4'd14: return s == v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] eff_model();
        logic pop_ok;
        pop_ok = pop && !push && (m_stk.size() != 0);
        return (latch && load_n && !pop_ok) ? alu : m_f;
    endfunction

    task automatic model_reset();
        m_f = 5'h00;
        m_err = 1'b0;
        m_stk.delete();
        exp_q.delete();
    endtask

    // One clock: check the same-cycle branch, predict the edge, then compare.
    task automatic tick(input string tag);
        logic       pop_ok;
        logic [4:0] nf, bus_v, got;
        #1 chk({tag, "/cond"}, 32'(cond_taken), 32'(cond_model(cond, eff_model())));
        pop_ok = pop && !push && (m_stk.size() != 0);
        bus_v  = drv_en ? drv[4:0] : (!assert_n ? m_f : 5'h1f);
        nf = m_f;
        if (!load_n)      nf = bus_v;
        else if (pop_ok)  nf = m_stk[$];
        else if (latch)   nf = alu;
        if (push && !pop) begin
            if (m_stk.size() == STACK_DEPTH) m_err = 1'b1;
            else m_stk.push_back(m_f);
        end
        if (pop && !push) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else void'(m_stk.pop_back());
        end
        m_f = nf;
        exp_q.push_back(nf);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({tag, "/flags"}, 32'(flags_out), 32'(got));
        chk({tag, "/lcarry"}, 32'(lcarry), 32'(got[4]));
        chk({tag, "/depth"}, 32'(depth), 32'(m_stk.size()));
        chk({tag, "/err"}, 32'(err), 32'(m_err));
    endtask

    task automatic check_conds(input string tag);
        for (int c = 0; c < 16; c++) begin
            cond = 4'(c);
            #1 chk($sformatf("%s/cond%0d", tag, c), 32'(cond_taken), 32'(cond_model(cond, eff_model())));
        end
    endtask

    task automatic idle();
        latch = 0; load_n = 1; assert_n = 1; push = 0; pop = 0; drv_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; alu = 0; cond = 0; drv = 0; idle();
        model_reset();
        #1;
        chk("reset/flags", 32'(flags_out), 32'h0);
        chk("reset/lcarry", 32'(lcarry), 32'h0);
        chk("reset/depth", 32'(depth), 32'h0);
        chk("reset/err", 32'(err), 32'h0);
        chk("reset/bus_z", 32'(main_bus), 32'hff);
        @(posedge clk); #1 rst = 0;

        // Capture V=1 S=0 Z=1 CA=0 CL=1 and read it back over the bus.
        latch = 1; alu = 5'b10101; cond = 4'd1;
        tick("capture");
        idle();
        assert_n = 0;
        #1 chk("assert/bus", 32'(main_bus), 32'h15);
        check_conds("held15");
        assert_n = 1;

        // Same-cycle bypass: F.Z=0 but the incoming ALU result has Z=1.
        latch = 1; alu = 5'h00; tick("clearz");
        latch = 1; alu = 5'h04; check_conds("bypass");
        cond = 4'd5; tick("bypass_z");
        idle();

        // Bus load wins over a simultaneous latch; upper bus bits ignored.
        load_n = 0; drv_en = 1; drv = 8'hff; latch = 1; alu = 5'h00;
        tick("load_ff");
        idle();
        // Assert and load together: F reloads its own value.
        latch = 1; alu = 5'h0a; tick("pre_selfload");
        idle(); load_n = 0; assert_n = 0; latch = 1; alu = 5'h11;
        tick("selfload");
        idle();

        // Fill the stack with 03,04,05,06 and overflow once.
        latch = 1; alu = 5'h03; tick("f03");
        push = 1; alu = 5'h04; tick("push03");
        alu = 5'h05; tick("push04");
        alu = 5'h06; tick("push05");
        latch = 0; tick("push06");
        tick("push_over");
        push = 0;
        pop = 1;
        for (int i = 0; i < 4; i++) tick($sformatf("pop%0d", i));
        idle();

        // Async reset between edges, in the middle of a push.
        latch = 1; alu = 5'h1b; tick("pre_rst");
        idle(); push = 1; assert_n = 1;
        #20 rst = 1;
        #1;
        chk("arst/flags", 32'(flags_out), 32'h0);
        chk("arst/depth", 32'(depth), 32'h0);
        chk("arst/err", 32'(err), 32'h0);
        chk("arst/bus_z", 32'(main_bus), 32'hff);
        model_reset();
        push = 0;
        @(posedge clk); #1 rst = 0;

        // Push twice, then push+pop together: no change, no error.
        latch = 1; alu = 5'h09; tick("f09");
        idle(); push = 1; tick("pushA"); tick("pushB");
        pop = 1; latch = 1; alu = 5'h12; tick("pushpop");
        idle(); pop = 1; tick("popA"); tick("popB");
        // Underflow: pop ignored, the lower-priority latch still applies.
        latch = 1; alu = 5'h08; cond = 4'd7; tick("pop_under");
        idle();

        for (int i = 0; i < 6; i++) begin
            latch = 1'($urandom_range(0, 1));
            alu = 5'($urandom_range(0, 31));
            cond = 4'($urandom_range(0, 15));
            tick($sformatf("rand%0d", i));
        end
        idle(); alu = 5'($urandom_range(0, 31));
        check_conds("rand_hold");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/flags_register.md
Name: flags_register

Overview:
- Architectural flags register directly downstream of the ALU: captures the five ALU flags (Overflow, Sign, Zero, CarryA, CarryL) at the end of each ALU operation.
- Feeds the registered logical carry back to the ALU shift stage as LCarryIn.
- Exposes the flags byte on MainBus for push/load and holds a small shadow stack for interrupt entry/exit.
- Evaluates the 4-bit branch condition for the jump logic, with bypass of same-cycle ALU results.

Parameters:
- STACK_DEPTH, 4, number of shadow-stack entries (power of two, 2..8).
- PTR_W, 2, log2(STACK_DEPTH); depth counter is PTR_W+1 bits.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Flags_0_Overflow  input  1  ALU overflow flag.
- Flags_1_Sign  input  1  ALU sign flag.
- Flags_2_Zero  input  1  ALU zero flag.
- Flags_3_CarryA  input  1  ALU arithmetic carry.
- Flags_4_CarryL  input  1  ALU logical/shift carry.
- FlagsLatch  input  1  high: ALU op completes this cycle, capture flags.
- MainBus  inout  8  shared data bus.
- Flags_Load_n  input  1  active low: load F from MainBus.
- Flags_Assert_n  input  1  active low: drive F onto MainBus.
- StackPush  input  1  push current F onto shadow stack.
- StackPop  input  1  pop top of shadow stack into F.
- Cond  input  4  branch condition select.
- CondTaken  output  1  condition result.
- LCarryIn  output  1  registered CarryL to ALU.
- FlagsOut  output  5  current F[4:0], for debug and status.
- StackDepth  output  PTR_W+1  number of valid stack entries.
- StackErr  output  1  sticky push-overflow / pop-underflow error.

Behaviour:
- F bit map: 0 V, 1 S, 2 Z, 3 CA, 4 CL.
- Bus byte: bits 4:0 = F; bits 7:5 read as 0 and are ignored on load.
- Reset (async) sets F=0, StackDepth=0 and StackErr=0; stack contents are don't-care. Outputs at reset: LCarryIn=0, FlagsOut=0, CondTaken=Cond-dependent on F=0, MainBus=Z.
- F update priority per edge: Flags_Load_n=0 > StackPop (valid) > FlagsLatch > hold.
- All F sources have 1-cycle latency: visible on FlagsOut/LCarryIn the cycle after the edge.
- LCarryIn = F[4], registered. No combinational path from ALU inputs.
- MainBus is driven with {3'b0,F} only while Flags_Assert_n=0, otherwise Z.
- Flags_Assert_n=0 and Flags_Load_n=0 together: bus is driven with old F and F reloads the same value; no conflict.
- Push:
  - Writes the pre-edge F to stack[depth] and increments depth.
  - Push when depth==STACK_DEPTH: write dropped, depth unchanged, StackErr set.
- Pop:
  - Loads F from stack[depth-1] and decrements depth.
  - Pop when depth==0: F unchanged by the pop (a lower-priority FlagsLatch still applies), StackErr set.
- StackPush and StackPop in the same cycle: net no-op on stack and depth, no error; F follows the remaining sources.
- Pop overrides a same-cycle FlagsLatch (the interrupt-return case); Load overrides both.
- StackErr is sticky until Reset.
- CondTaken is combinational on the effective flags E:
  - E = incoming ALU flags when FlagsLatch=1 and no Load/Pop is active this cycle; otherwise E = F.
  - This bypass gives zero-bubble compare-and-branch.
- Cond encoding:
  - 0 always, 1 V, 2 !V, 3 S, 4 !S, 5 Z, 6 !Z.
  - 7 CA, 8 !CA, 9 CL, 10 !CL.
  - 11 CA|Z, 12 !CA&!Z.
  - 13 S^V (signed less), 14 !(S^V), 15 never.
- Reset deasserted mid-sequence: state restarts from the reset values; there is no partial-op recovery.

Decomposition:
- Shared package alu_pkg:
  - flag bit index constants (FLAG_V..FLAG_CL), FLAG_W=5.
  - Cond encoding localparams COND_ALWAYS..COND_NEVER.
  - bus byte pad width.
- One sub-module: flags_stack (LIFO array, depth counter, error flag) with push/pop/data in/data out.
- Condition evaluation stays inline as a case statement.

Test Plan:
- Reset, then FlagsLatch=1 with V=1,S=0,Z=1,CA=0,CL=1 -> next cycle FlagsOut=5'b10101, LCarryIn=1, Flags_Assert_n=0 drives MainBus=8'h15.
- Same-cycle FlagsLatch with Z=1 and Cond=5 while F.Z=0 -> CondTaken=1 in that cycle. Cond=15 -> 0. Cond=0 -> 1.
- Flags_Load_n=0 with MainBus=8'hFF and FlagsLatch=1 -> F=5'h1F (bus wins, bits 7:5 ignored).
- Push F=5'h03, 5'h04, 5'h05, 5'h06, then a 5th push -> StackDepth=4, StackErr=1. Four pops -> F sequence 06,05,04,03, depth 0.
- Pop at depth 0 with FlagsLatch=1, ALU flags=5'h08 -> F=5'h08, StackErr=1. Simultaneous push+pop at depth 2 -> depth stays 2, no error.
- Assert Reset asynchronously mid-push (between edges) -> F=0, StackDepth=0, StackErr=0, MainBus=Z immediately without a clock edge.
